// File: rtl/ddr_rd_ctrl.sv
// DDR3 read scheduler: issues fixed-length read bursts over a circular address
// window whenever the read-path FIFO can take a full burst, and forwards beats.
module ddr_rd_ctrl #(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = 128,
  parameter int BURST_LEN        = 16,
  parameter int ADDR_STEP        = 128,
  parameter int FIFO_DEPTH_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_start,
  input  logic                        rd_stop,
  input  logic [ADDR_WIDTH-1:0]       rd_base_addr,
  input  logic [ADDR_WIDTH-1:0]       rd_end_addr,
  input  logic [FIFO_DEPTH_WIDTH:0]   wr_water_level,
  input  logic                        wr_full,
  output logic [ADDR_WIDTH-1:0]       m_araddr,
  output logic [7:0]                  m_arlen,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [DATA_WIDTH-1:0]       m_rdata,
  input  logic                        m_rvalid,
  input  logic                        m_rlast,
  output logic                        m_rready,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  output logic                        busy,
  output logic [15:0]                 burst_cnt,
  output logic                        err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [7:0]                LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [FIFO_DEPTH_WIDTH:0] SPACE_LIMIT =
    (FIFO_DEPTH_WIDTH + 1)'((2 ** FIFO_DEPTH_WIDTH) - BURST_LEN);
  localparam logic [ADDR_WIDTH:0]       STEP_EXT    = (ADDR_WIDTH + 1)'(ADDR_STEP);

  state_t                  state_r, next_state_s;
  logic [ADDR_WIDTH-1:0]   base_addr_r, end_addr_r, cur_addr_r;
  logic [7:0]              beat_cnt_r;
  logic                    stop_pending_r;
  logic [ADDR_WIDTH-1:0]   m_araddr_r;
  logic                    m_arvalid_r, m_rready_r, fifo_wr_en_r, busy_r, err_r;
  logic [DATA_WIDTH-1:0]   fifo_wr_data_r;
  logic [15:0]             burst_cnt_r;

  logic                    space_s, stop_s, beat_fire_s, beat_last_s, burst_done_s;
  logic [ADDR_WIDTH:0]     next_addr_s;
  logic [ADDR_WIDTH-1:0]   wrap_addr_s;

  assign m_araddr     = m_araddr_r;
  assign m_arlen      = LAST_BEAT;
  assign m_arvalid    = m_arvalid_r;
  assign m_rready     = m_rready_r;
  assign fifo_wr_en   = fifo_wr_en_r;
  assign fifo_wr_data = fifo_wr_data_r;
  assign busy         = busy_r;
  assign burst_cnt    = burst_cnt_r;
  assign err          = err_r;

  // Beat bookkeeping and circular address advance (extra bit keeps the compare exact).
  always_comb begin
    space_s      = (wr_water_level <= SPACE_LIMIT) && !wr_full;
    stop_s       = stop_pending_r | rd_stop;
    beat_fire_s  = (state_r == ST_DATA) && m_rvalid && m_rready_r;
    beat_last_s  = (beat_cnt_r == LAST_BEAT);
    burst_done_s = beat_fire_s && (m_rlast || beat_last_s);
    next_addr_s  = {1'b0, cur_addr_r} + STEP_EXT;
    if (next_addr_s >= {1'b0, end_addr_r}) begin
      wrap_addr_s = base_addr_r;
    end else begin
      wrap_addr_s = next_addr_s[ADDR_WIDTH-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_start) next_state_s = ST_CHECK;
        else          next_state_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (stop_s)       next_state_s = ST_IDLE;
        else if (space_s) next_state_s = ST_ADDR;
        else              next_state_s = ST_CHECK;
      end
      ST_ADDR: begin
        if (m_arvalid_r && m_arready) next_state_s = ST_DATA;
        else                          next_state_s = ST_ADDR;
      end
      ST_DATA: begin
        if (burst_done_s) next_state_s = ST_CHECK;
        else              next_state_s = ST_DATA;
      end
      ST_DRAIN: next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Registered outputs, window registers and burst/beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr_r    <= '0;
      end_addr_r     <= '0;
      cur_addr_r     <= '0;
      beat_cnt_r     <= 8'd0;
      stop_pending_r <= 1'b0;
      m_araddr_r     <= '0;
      m_arvalid_r    <= 1'b0;
      m_rready_r     <= 1'b0;
      fifo_wr_en_r   <= 1'b0;
      fifo_wr_data_r <= '0;
      busy_r         <= 1'b0;
      burst_cnt_r    <= 16'd0;
      err_r          <= 1'b0;
    end else begin
      m_arvalid_r  <= (next_state_s == ST_ADDR);
      m_rready_r   <= (next_state_s == ST_DATA);
      busy_r       <= (next_state_s != ST_IDLE);
      fifo_wr_en_r <= beat_fire_s;
      if (beat_fire_s) fifo_wr_data_r <= m_rdata;

      if (state_r == ST_IDLE && rd_start) begin
        base_addr_r <= rd_base_addr;
        end_addr_r  <= rd_end_addr;
        cur_addr_r  <= rd_base_addr;
        burst_cnt_r <= 16'd0;
        err_r       <= 1'b0;
      end

      // A stop is only honoured at a burst boundary, so it is remembered until then.
      if (state_r == ST_IDLE || next_state_s == ST_IDLE) stop_pending_r <= 1'b0;
      else if (rd_stop)                                  stop_pending_r <= 1'b1;

      if (state_r == ST_CHECK && next_state_s == ST_ADDR) m_araddr_r <= cur_addr_r;

      if (state_r == ST_ADDR && next_state_s == ST_DATA) beat_cnt_r <= 8'd0;
      else if (beat_fire_s)                              beat_cnt_r <= beat_cnt_r + 8'd1;

      if (beat_fire_s && (m_rlast != beat_last_s)) err_r <= 1'b1;

      if (burst_done_s) begin
        burst_cnt_r <= burst_cnt_r + 16'd1;
        cur_addr_r  <= wrap_addr_s;
      end
    end
  end

endmodule

// File: tb/tb_ddr_rd_ctrl.sv
// Directed bench for ddr_rd_ctrl: a table of FIFO-level/full vectors plus
// hand-written burst sequences (wrap, backpressure, early rlast, stop, reset).
module tb_ddr_rd_ctrl;

  logic         clk = 1'b0;
  logic         rst, rd_start, rd_stop, wr_full, m_arready, m_rvalid, m_rlast;
  logic [27:0]  rd_base_addr, rd_end_addr;
  logic [10:0]  wr_water_level;
  logic [127:0] m_rdata;
  logic [27:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic         m_arvalid, m_rready, fifo_wr_en, busy, err;
  logic [127:0] fifo_wr_data;
  logic [15:0]  burst_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ddr_rd_ctrl dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_stop(rd_stop),
    .rd_base_addr(rd_base_addr), .rd_end_addr(rd_end_addr),
    .wr_water_level(wr_water_level), .wr_full(wr_full),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_rlast(m_rlast), .m_rready(m_rready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .busy(busy), .burst_cnt(burst_cnt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [10:0] level;
    logic        full;
    logic [27:0] base;
    logic        exp_issue;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_start = 1'b0; rd_stop = 1'b0; wr_full = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    wr_water_level = 11'd0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic start(input logic [27:0] base, input logic [27:0] end_a);
    rd_base_addr = base; rd_end_addr = end_a;
    rd_start = 1'b1; step(); rd_start = 1'b0;
  endtask

  // Waits for the address request, accepts it, then returns nbeats beats.
  task automatic serve_burst(input logic [27:0] exp_addr, input int nbeats,
                             input int rlast_idx, input int stop_idx);
    int wait_c;
    int good_wr;
    logic [127:0] exp_d;
    wait_c = 0;
    good_wr = 0;
    while (!m_arvalid && wait_c < 50) begin
      step();
      wait_c++;
    end
    chk("arvalid_seen", {127'd0, m_arvalid}, 128'd1);
    chk("araddr", {100'd0, m_araddr}, {100'd0, exp_addr});
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk("arvalid_drop", {127'd0, m_arvalid}, 128'd0);
    for (int i = 0; i < nbeats; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = {$urandom, $urandom, $urandom, $urandom};
      m_rlast  = (i == rlast_idx);
      rd_stop  = (i == stop_idx);
      exp_d    = m_rdata;
      step();
      rd_stop  = 1'b0;
      if (fifo_wr_en === 1'b1 && fifo_wr_data === exp_d) good_wr++;
      else $display("FAIL beat_%0d: wr_en=%0b data=%0h expected data=%0h",
                    i, fifo_wr_en, fifo_wr_data, exp_d);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    chk("beats_written", 128'(good_wr), 128'(nbeats));
    step();
    chk("no_extra_wr", {127'd0, fifo_wr_en}, 128'd0);
  endtask

  initial begin
    int flag;
    logic [27:0] held_addr;
    logic [27:0] exp_seq[5];

    vecs[0] = '{level: 11'd0,    full: 1'b0, base: 28'h0000000, exp_issue: 1'b1};
    vecs[1] = '{level: 11'd1008, full: 1'b0, base: 28'h0000400, exp_issue: 1'b1};
    vecs[2] = '{level: 11'd1009, full: 1'b0, base: 28'h0000080, exp_issue: 1'b0};
    vecs[3] = '{level: 11'd1024, full: 1'b0, base: 28'h0000100, exp_issue: 1'b0};
    vecs[4] = '{level: 11'd1008, full: 1'b1, base: 28'h0000180, exp_issue: 1'b0};
    vecs[5] = '{level: 11'd500,  full: 1'b1, base: 28'h0000200, exp_issue: 1'b0};
    vecs[6] = '{level: 11'd2047, full: 1'b0, base: 28'h0000280, exp_issue: 1'b0};
    vecs[7] = '{level: 11'd1,    full: 1'b0, base: 28'hFFFFF80, exp_issue: 1'b1};
    exp_seq[0] = 28'h000; exp_seq[1] = 28'h080; exp_seq[2] = 28'h100;
    exp_seq[3] = 28'h180; exp_seq[4] = 28'h000;
    rd_base_addr = '0;
    rd_end_addr  = '0;

    // Reset values.
    do_reset();
    chk("rst_arvalid", {127'd0, m_arvalid}, 128'd0);
    chk("rst_rready", {127'd0, m_rready}, 128'd0);
    chk("rst_wr_en", {127'd0, fifo_wr_en}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_araddr", {100'd0, m_araddr}, 128'd0);
    chk("rst_burst_cnt", {112'd0, burst_cnt}, 128'd0);
    chk("rst_wr_data", fifo_wr_data, 128'd0);
    chk("arlen", {120'd0, m_arlen}, 128'd15);

    // Table: FIFO space decision.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      wr_water_level = vecs[v].level;
      wr_full        = vecs[v].full;
      start(vecs[v].base, vecs[v].base + 28'h200);
      step(); step();
      chk($sformatf("vec%0d_arvalid", v), {127'd0, m_arvalid}, {127'd0, vecs[v].exp_issue});
      chk($sformatf("vec%0d_busy", v), {127'd0, busy}, 128'd1);
      if (vecs[v].exp_issue)
        chk($sformatf("vec%0d_araddr", v), {100'd0, m_araddr}, {100'd0, vecs[v].base});
    end

    // Window walk with wrap.
    do_reset();
    start(28'h000, 28'h200);
    for (int b = 0; b < 5; b++) begin
      serve_burst(exp_seq[b], 16, 15, -1);
      chk($sformatf("walk_burst_cnt%0d", b), {112'd0, burst_cnt}, 128'(b + 1));
    end
    chk("walk_err", {127'd0, err}, 128'd0);

    // Level threshold crossing then address backpressure.
    do_reset();
    wr_water_level = 11'd1009;
    start(28'h300, 28'h400);
    flag = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (m_arvalid) flag = 1;
    end
    chk("level1009_no_arvalid", 128'(flag), 128'd0);
    wr_water_level = 11'd1008;
    step(); step();
    chk("level1008_arvalid", {127'd0, m_arvalid}, 128'd1);
    held_addr = m_araddr;
    chk("held_addr_base", {100'd0, held_addr}, 128'h300);
    flag = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (m_arvalid !== 1'b1 || m_araddr !== held_addr) flag = 1;
    end
    chk("arvalid_stable", 128'(flag), 128'd0);
    serve_burst(28'h300, 16, 15, -1);
    chk("bp_burst_cnt", {112'd0, burst_cnt}, 128'd1);

    // Early rlast, sticky err, then reset while in ADDR.
    do_reset();
    start(28'h000, 28'h200);
    serve_burst(28'h000, 12, 11, -1);
    chk("early_err", {127'd0, err}, 128'd1);
    chk("early_burst_cnt", {112'd0, burst_cnt}, 128'd1);
    serve_burst(28'h080, 16, 15, -1);
    chk("err_sticky", {127'd0, err}, 128'd1);
    chk("after_early_cnt", {112'd0, burst_cnt}, 128'd2);
    step();
    chk("in_addr_arvalid", {127'd0, m_arvalid}, 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_addr_arvalid", {127'd0, m_arvalid}, 128'd0);
    chk("rst_addr_busy", {127'd0, busy}, 128'd0);
    chk("rst_addr_cnt", {112'd0, burst_cnt}, 128'd0);
    chk("rst_addr_err", {127'd0, err}, 128'd0);

    // Stop mid-burst, then restart at base.
    do_reset();
    start(28'h040, 28'h1000);
    serve_burst(28'h040, 16, 15, -1);
    serve_burst(28'h0C0, 16, 15, 5);
    chk("stop_burst_cnt", {112'd0, burst_cnt}, 128'd2);
    chk("stop_busy", {127'd0, busy}, 128'd0);
    flag = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (m_arvalid) flag = 1;
    end
    chk("stop_no_arvalid", 128'(flag), 128'd0);
    start(28'h040, 28'h1000);
    chk("restart_cnt", {112'd0, burst_cnt}, 128'd0);
    chk("restart_busy", {127'd0, busy}, 128'd1);
    serve_burst(28'h040, 16, 15, -1);

    // Empty window: every burst reads base.
    do_reset();
    start(28'h100, 28'h100);
    serve_burst(28'h100, 16, 15, -1);
    serve_burst(28'h100, 16, 15, -1);
    chk("zero_win_cnt", {112'd0, burst_cnt}, 128'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
